// File: rtl/exp_sigma_accumulator_if.sv
// exp_sigma_accumulator_if: generator write stream, result handshake and result bus
interface exp_sigma_accumulator_if #(
   parameter int DATA_W = 18,
   parameter int ADDR_W = 10,
   parameter int SUM_W = 28
);
   logic [DATA_W-1:0] iData;
   logic [ADDR_W-1:0] iAddr;
   logic iValid;
   logic iDone;
   logic iAck;
   logic [SUM_W-1:0] oSum;
   logic [DATA_W-1:0] oMax;
   logic [ADDR_W-1:0] oMaxAddr;
   logic [ADDR_W:0] oCount;
   logic oResultValid;
   logic oError;
   logic oBusy;
   modport master (
      output iData, iAddr, iValid, iDone, iAck,
      input oSum, oMax, oMaxAddr, oCount, oResultValid, oError, oBusy
   );
   modport slave (
      input iData, iAddr, iValid, iDone, iAck,
      output oSum, oMax, oMaxAddr, oCount, oResultValid, oError, oBusy
   );
endinterface

// File: rtl/exp_sigma_accumulator.sv
// exp_sigma_accumulator: reduces one exp-sigma table pass to sum, max, max address and count
module exp_sigma_accumulator #(
   parameter int DATA_W = 18,
   parameter int ADDR_W = 10,
   parameter int DEPTH = 1024,
   parameter int SUM_W = 28
) (
   input logic CLK,
   input logic iRst_n,
   exp_sigma_accumulator_if.slave bus
);
   localparam logic [ADDR_W:0] FULL = (ADDR_W+1)'(DEPTH);
   typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;
   state_t state;
   logic take;
   logic [ADDR_W:0] countNext;
   // a sample is only absorbed while the pass still has room for it
   always_comb begin
      take = bus.iValid && (bus.oCount != FULL);
      countNext = bus.oCount + (ADDR_W+1)'(take);
   end
   assign bus.oBusy = (state == ACCUM);
   // pass sequencing and result registers
   always_ff @(posedge CLK) begin
      if (!iRst_n) begin
         state <= IDLE;
         bus.oSum <= '0;
         bus.oMax <= '0;
         bus.oMaxAddr <= '0;
         bus.oCount <= '0;
         bus.oResultValid <= 1'b0;
         bus.oError <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.iValid) begin
                  if (bus.iAddr == '0) begin
                     state <= ACCUM;
                     bus.oSum <= SUM_W'(bus.iData);
                     bus.oMax <= bus.iData;
                     bus.oMaxAddr <= '0;
                     bus.oCount <= (ADDR_W+1)'(1);
                     bus.oError <= 1'b0;
                  end else begin
                     bus.oError <= 1'b1;
                  end
               end
            end
            ACCUM: begin
               if (take) begin
                  bus.oSum <= bus.oSum + SUM_W'(bus.iData);
                  bus.oCount <= countNext;
                  if (bus.iAddr != bus.oCount[ADDR_W-1:0]) bus.oError <= 1'b1;
                  if (bus.iData > bus.oMax) begin
                     bus.oMax <= bus.iData;
                     bus.oMaxAddr <= bus.iAddr;
                  end
               end else if (bus.iValid) begin
                  bus.oError <= 1'b1;
               end
               if (bus.iDone) begin
                  state <= HOLD;
                  bus.oResultValid <= 1'b1;
                  if (countNext != FULL) bus.oError <= 1'b1;
               end
            end
            HOLD: begin
               if (bus.iValid) bus.oError <= 1'b1;
               if (bus.iAck) begin
                  state <= IDLE;
                  bus.oResultValid <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_exp_sigma_accumulator.sv
// tb_exp_sigma_accumulator: table-driven and random pass checks against a pass-level model
module tb_exp_sigma_accumulator;
   localparam int DATA_W = 18;
   localparam int ADDR_W = 10;
   localparam int DEPTH = 1024;
   localparam int SUM_W = 28;

   typedef struct {
      int kind;
      int param;
      bit doneLast;
      bit useModel;
      longint eSum;
      int eMax;
      int eMaxAddr;
      int eCount;
      bit eErr;
   } vec_t;

   logic clk = 1'b0;
   logic rstN = 1'b0;
   int checks = 0;
   int errors = 0;
   int qAddr[$];
   int qData[$];
   longint mSum;
   int mMax, mMaxAddr, mCount;
   bit mErr;
   vec_t vecs[8];

   always #5 clk = ~clk;

   exp_sigma_accumulator_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .SUM_W(SUM_W)) bus ();
   exp_sigma_accumulator #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .SUM_W(SUM_W)) dut (
      .CLK(clk),
      .iRst_n(rstN),
      .bus(bus)
   );

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", name, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkResult(input string tag, input longint s, input int mx, input int ma, input int c, input bit e);
      check({tag, " sum"}, 64'(bus.oSum), s);
      check({tag, " max"}, 64'(bus.oMax), 64'(mx));
      check({tag, " maxAddr"}, 64'(bus.oMaxAddr), 64'(ma));
      check({tag, " count"}, 64'(bus.oCount), 64'(c));
      check({tag, " error"}, 64'(bus.oError), 64'(e));
   endtask

   // pass-level reference: accepted entries are summed, the first largest wins,
   // any out-of-order address or overrun or short pass marks the error
   task automatic modelStart();
      mSum = 0; mMax = 0; mMaxAddr = 0; mCount = 0; mErr = 1'b0;
   endtask

   task automatic modelSample(input int a, input int d);
      if (mCount == DEPTH) begin
         mErr = 1'b1;
         return;
      end
      if (a != mCount) mErr = 1'b1;
      mSum += d;
      if (mCount == 0 || d > mMax) begin
         mMax = d;
         mMaxAddr = a;
      end
      mCount++;
   endtask

   task automatic modelDone();
      if (mCount != DEPTH) mErr = 1'b1;
   endtask

   task automatic build(input int kind, input int param);
      int bad;
      qAddr.delete();
      qData.delete();
      bad = $urandom_range(DEPTH - 1, 1);
      for (int a = 0; a < DEPTH; a++) begin
         case (kind)
            0: begin qAddr.push_back(a); qData.push_back(a); end
            1: begin qAddr.push_back(a); qData.push_back(param); end
            2: if (a != param) begin qAddr.push_back(a); qData.push_back(a); end
            3: begin qAddr.push_back(a); qData.push_back(a); end
            4: begin qAddr.push_back(a); qData.push_back(int'($urandom_range(param, 0))); end
            default: begin
               qAddr.push_back(a == bad ? (a + 7) % DEPTH : a);
               qData.push_back(int'($urandom_range(param, 0)));
            end
         endcase
      end
      if (kind == 3) begin qAddr.push_back(0); qData.push_back(0); end
   endtask

   task automatic runPass(input string tag, input bit doneLast);
      int last;
      last = qAddr.size() - 1;
      modelStart();
      for (int i = 0; i <= last; i++) begin
         bus.iValid = 1'b1;
         bus.iAddr = ADDR_W'(qAddr[i]);
         bus.iData = DATA_W'(qData[i]);
         bus.iDone = doneLast && (i == last);
         tick();
         modelSample(qAddr[i], qData[i]);
         if (doneLast && i == last) modelDone();
         if (i % 128 == 0 || (i >= 498 && i <= 502) || i == last) begin
            check($sformatf("%s count@%0d", tag, i), 64'(bus.oCount), 64'(mCount));
            check($sformatf("%s error@%0d", tag, i), 64'(bus.oError), 64'(mErr));
            check($sformatf("%s busy@%0d", tag, i), 64'(bus.oBusy), 64'(!(doneLast && i == last)));
         end
      end
      bus.iValid = 1'b0;
      bus.iDone = 1'b0;
      if (!doneLast) begin
         bus.iDone = 1'b1;
         tick();
         bus.iDone = 1'b0;
         modelDone();
      end
      check({tag, " resultValid"}, 64'(bus.oResultValid), 64'd1);
      check({tag, " busyHold"}, 64'(bus.oBusy), 64'd0);
   endtask

   task automatic ackResult(input string tag);
      bus.iAck = 1'b1;
      tick();
      bus.iAck = 1'b0;
      check({tag, " ackValid"}, 64'(bus.oResultValid), 64'd0);
      check({tag, " ackBusy"}, 64'(bus.oBusy), 64'd0);
   endtask

   initial begin
      longint frozenSum;
      vecs[0] = '{0, 0, 1'b0, 1'b0, 523776, 1023, 1023, 1024, 1'b0};
      vecs[1] = '{1, 3408, 1'b1, 1'b0, 3489792, 3408, 0, 1024, 1'b0};
      vecs[2] = '{2, 500, 1'b0, 1'b0, 523276, 1023, 1023, 1023, 1'b1};
      vecs[3] = '{3, 0, 1'b0, 1'b0, 523776, 1023, 1023, 1024, 1'b1};
      vecs[4] = '{4, 262143, 1'b0, 1'b1, 0, 0, 0, 0, 1'b0};
      vecs[5] = '{4, 262143, 1'b1, 1'b1, 0, 0, 0, 0, 1'b0};
      vecs[6] = '{5, 262143, 1'b0, 1'b1, 0, 0, 0, 0, 1'b0};
      vecs[7] = '{4, 3, 1'b1, 1'b1, 0, 0, 0, 0, 1'b0};
      bus.iData = '0; bus.iAddr = '0; bus.iValid = 1'b0; bus.iDone = 1'b0; bus.iAck = 1'b0;
      tick();
      tick();
      checkResult("reset", 0, 0, 0, 0, 1'b0);
      check("reset resultValid", 64'(bus.oResultValid), 64'd0);
      check("reset busy", 64'(bus.oBusy), 64'd0);
      rstN = 1'b1;
      bus.iDone = 1'b1;
      tick();
      bus.iDone = 1'b0;
      bus.iAck = 1'b1;
      tick();
      bus.iAck = 1'b0;
      check("idle done resultValid", 64'(bus.oResultValid), 64'd0);
      check("idle done busy", 64'(bus.oBusy), 64'd0);
      bus.iValid = 1'b1; bus.iAddr = ADDR_W'(5); bus.iData = DATA_W'(9);
      tick();
      bus.iValid = 1'b0;
      checkResult("idle bad addr", 0, 0, 0, 0, 1'b1);
      check("idle bad addr busy", 64'(bus.oBusy), 64'd0);

      for (int r = 0; r < 8; r++) begin
         string tag;
         tag = $sformatf("row%0d", r);
         build(vecs[r].kind, vecs[r].param);
         runPass(tag, vecs[r].doneLast);
         if (vecs[r].useModel) checkResult(tag, mSum, mMax, mMaxAddr, mCount, mErr);
         else checkResult(tag, vecs[r].eSum, vecs[r].eMax, vecs[r].eMaxAddr, vecs[r].eCount, vecs[r].eErr);
         ackResult(tag);
      end

      build(0, 0);
      runPass("hs", 1'b0);
      frozenSum = mSum;
      for (int c = 0; c < 20; c++) begin
         bus.iValid = (c == 3);
         bus.iAddr = '0;
         bus.iData = DATA_W'(77);
         tick();
         bus.iValid = 1'b0;
         check($sformatf("hs sum@%0d", c), 64'(bus.oSum), frozenSum);
         check($sformatf("hs count@%0d", c), 64'(bus.oCount), 64'(DEPTH));
         check($sformatf("hs valid@%0d", c), 64'(bus.oResultValid), 64'd1);
         check($sformatf("hs error@%0d", c), 64'(bus.oError), 64'(c >= 3));
      end
      ackResult("hs");
      check("hs keep error", 64'(bus.oError), 64'd1);
      check("hs keep sum", 64'(bus.oSum), frozenSum);
      build(4, 262143);
      runPass("hsNext", 1'b1);
      checkResult("hsNext", mSum, mMax, mMaxAddr, mCount, mErr);
      ackResult("hsNext");

      for (int a = 0; a <= 300; a++) begin
         bus.iValid = 1'b1;
         bus.iAddr = ADDR_W'(a);
         bus.iData = DATA_W'(a);
         if (a == 300) rstN = 1'b0;
         tick();
      end
      rstN = 1'b1;
      bus.iValid = 1'b0;
      checkResult("midReset", 0, 0, 0, 0, 1'b0);
      check("midReset busy", 64'(bus.oBusy), 64'd0);
      check("midReset valid", 64'(bus.oResultValid), 64'd0);
      for (int a = 301; a < 306; a++) begin
         bus.iValid = 1'b1;
         bus.iAddr = ADDR_W'(a);
         bus.iData = DATA_W'(a);
         tick();
      end
      bus.iValid = 1'b0;
      checkResult("afterReset", 0, 0, 0, 0, 1'b1);
      check("afterReset busy", 64'(bus.oBusy), 64'd0);
      build(4, 262143);
      runPass("fresh", 1'b0);
      checkResult("fresh", mSum, mMax, mMaxAddr, mCount, mErr);
      ackResult("fresh");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
